// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the register-dump FSM state type
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} dump_state_t;
endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: read-port and valid/ready output stream of the register dumper
interface regfile_dump_if;
  import cpu_pkg::*;
  logic start;
  logic [REG_ADDR_W-1:0] ra;
  logic [XLEN-1:0] rd;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_data;
  logic [REG_ADDR_W-1:0] out_index;
  logic out_last;
  logic busy;
  logic done;
  modport slave(input start, rd, out_ready, output ra, out_valid, out_data, out_index, out_last, busy, done);
  modport master(output start, rd, out_ready, input ra, out_valid, out_data, out_index, out_last, busy, done);
endinterface

// File: rtl/regfile.sv
// regfile: 32 x XLEN register file, two combinational read ports, one write port, x0 reads zero
module regfile
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_wa,
  input  logic [XLEN-1:0]       i_wd,
  input  logic [REG_ADDR_W-1:0] i_ra1,
  output logic [XLEN-1:0]       o_rd1,
  input  logic [REG_ADDR_W-1:0] i_ra2,
  output logic [XLEN-1:0]       o_rd2
);
  logic [XLEN-1:0] r_regs [32];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    else if (i_we && i_wa != '0) r_regs[i_wa] <= i_wd;
  assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: streams registers FIRST_REG..LAST_REG out over valid/ready, one word per two cycles
module regfile_dump
  import cpu_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_dump_if.slave bus
);
  localparam logic [REG_ADDR_W-1:0] FIRST = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST = REG_ADDR_W'(LAST_REG);
  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_param_check
    $error("regfile_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end
  dump_state_t r_state, w_state;
  logic [REG_ADDR_W-1:0] r_idx, w_idx, r_ra, w_ra, r_index, w_index;
  logic [XLEN-1:0] r_data, w_data;
  logic r_valid, w_valid, r_last, w_last, r_done, w_done;
  logic w_at_last;
  assign w_at_last = r_idx == LAST;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ra    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_ra    <= w_ra;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_index <= w_index;
      r_last  <= w_last;
      r_done  <= w_done;
    end
  // the final word goes to FINISH instead of incrementing, so idx never wraps past 31
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_ra    = r_ra;
    w_valid = r_valid;
    w_data  = r_data;
    w_index = r_index;
    w_last  = r_last;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state = READ;
        w_idx   = FIRST;
        w_ra    = FIRST;
      end
      READ: begin
        w_state = SEND;
        w_data  = bus.rd;
        w_index = r_idx;
        w_last  = w_at_last;
        w_valid = 1'b1;
      end
      SEND: if (bus.out_ready) begin
        w_valid = 1'b0;
        w_state = w_at_last ? FINISH : READ;
        w_done  = w_at_last;
        w_idx   = w_at_last ? r_idx : r_idx + 1'b1;
        w_ra    = w_at_last ? r_ra : r_idx + 1'b1;
      end
      FINISH: begin
        w_state = IDLE;
        w_ra    = '0;
        w_last  = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end
  assign bus.ra        = r_ra;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_index = r_index;
  assign bus.out_last  = r_last;
  assign bus.done      = r_done;
  assign bus.busy      = r_state != IDLE;
endmodule
